// File: rtl/vga_ram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_ram_reader                                             |
// | Purpose  : Scan-out side of the radar frame buffer. Walks the video    |
// |            RAM in raster order, generates VGA timing and aligns the    |
// |            colour output with the RAM read latency.                    |
// | Revision : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vga_ram_reader #(
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter int   PIX_DIV     = 2,
   parameter int   RAM_LATENCY = 1,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [18:0] ram_addr,
   output logic        ram_rd,
   input  logic [2:0]  ram_q,
   output logic        vga_r,
   output logic        vga_g,
   output logic        vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start,
   output logic        vblank
);

   // ------------------------------------------------------------------
   // Derived geometry
   // ------------------------------------------------------------------
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int H_W     = $clog2(H_TOTAL + 1);
   localparam int V_W     = $clog2(V_TOTAL + 1);
   localparam int ADDR_W  = 19;

   localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(PIX_DIV - 1);
   localparam logic [H_W-1:0]    C_H_LAST    = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]    C_H_VIS     = H_W'(H_VISIBLE);
   localparam logic [H_W-1:0]    C_HS_START  = H_W'(H_VISIBLE + H_FRONT);
   localparam logic [H_W-1:0]    C_HS_END    = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [V_W-1:0]    C_V_LAST    = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]    C_V_VIS     = V_W'(V_VISIBLE);
   localparam logic [V_W-1:0]    C_VS_START  = V_W'(V_VISIBLE + V_FRONT);
   localparam logic [V_W-1:0]    C_VS_END    = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   generate
      if (RAM_LATENCY > PIX_DIV - 1) begin : g_latency_check
         $error("vga_ram_reader: RAM_LATENCY must be <= PIX_DIV-1");
      end
      if (H_VISIBLE * V_VISIBLE > (1 << ADDR_W)) begin : g_addr_check
         $error("vga_ram_reader: visible area does not fit the 19-bit address");
      end
   endgenerate

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DIV_W-1:0]  div_q,         div_d;
   logic [H_W-1:0]    h_cnt_q,       h_cnt_d;
   logic [V_W-1:0]    v_cnt_q,       v_cnt_d;
   logic [ADDR_W-1:0] addr_cnt_q,    addr_cnt_d;

   // stage 1: address phase
   logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
   logic              ram_rd_q,      ram_rd_d;
   logic              hs1_q,         hs1_d;
   logic              vs1_q,         vs1_d;
   logic              act1_q,        act1_d;

   // stage 2: pixel output phase
   logic [2:0]        rgb_q,         rgb_d;
   logic              vga_hs_q,      vga_hs_d;
   logic              vga_vs_q,      vga_vs_d;

   // frame-level status
   logic              frame_start_q, frame_start_d;
   logic              vblank_q,      vblank_d;

   // ------------------------------------------------------------------
   // Counter decode
   // ------------------------------------------------------------------
   logic tick;
   logic h_wrap;
   logic v_wrap;
   logic at_origin;
   logic act;
   logic hs_zone;
   logic vs_zone;

   assign tick      = (div_q == C_DIV_LAST) && enable;
   assign h_wrap    = (h_cnt_q == C_H_LAST);
   assign v_wrap    = (v_cnt_q == C_V_LAST);
   assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign act       = (h_cnt_q < C_H_VIS) && (v_cnt_q < C_V_VIS);
   assign hs_zone   = (h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END);
   assign vs_zone   = (v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END);

   // Next-state logic: idle while disabled, otherwise advance one pixel per tick
   always_comb begin
      div_d         = div_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      addr_cnt_d    = addr_cnt_q;
      ram_addr_d    = ram_addr_q;
      ram_rd_d      = ram_rd_q;
      hs1_d         = hs1_q;
      vs1_d         = vs1_q;
      act1_d        = act1_q;
      rgb_d         = rgb_q;
      vga_hs_d      = vga_hs_q;
      vga_vs_d      = vga_vs_q;
      frame_start_d = 1'b0;

      if (!enable) begin
         // Disabled looks exactly like reset so re-enable starts a fresh frame.
         div_d      = '0;
         h_cnt_d    = '0;
         v_cnt_d    = '0;
         addr_cnt_d = '0;
         ram_addr_d = '0;
         ram_rd_d   = 1'b0;
         hs1_d      = 1'b0;
         vs1_d      = 1'b0;
         act1_d     = 1'b0;
         rgb_d      = 3'b000;
         vga_hs_d   = ~HS_POL;
         vga_vs_d   = ~VS_POL;
      end else begin
         div_d = (div_q == C_DIV_LAST) ? '0 : div_q + 1'b1;

         if (tick) begin
            // Raster counters
            if (h_wrap) begin
               h_cnt_d = '0;
               v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end else begin
               h_cnt_d = h_cnt_q + 1'b1;
            end

            // Address walks with active pixels only; saturates at the last
            // visible pixel and restarts when the raster returns to (0,0).
            if (h_wrap && v_wrap) begin
               addr_cnt_d = '0;
            end else if (act && (addr_cnt_q != C_ADDR_LAST)) begin
               addr_cnt_d = addr_cnt_q + 1'b1;
            end

            // Stage 1 captures the current pixel's address and timing
            ram_addr_d = addr_cnt_q;
            ram_rd_d   = act;
            hs1_d      = hs_zone;
            vs1_d      = vs_zone;
            act1_d     = act;

            // Stage 2 pairs returned RAM data with the delayed timing
            rgb_d    = act1_q ? ram_q : 3'b000;
            vga_hs_d = hs1_q ? HS_POL : ~HS_POL;
            vga_vs_d = vs1_q ? VS_POL : ~VS_POL;

            frame_start_d = at_origin;
         end
      end

      // Follows the line counter itself, not the delayed pixel pipeline
      vblank_d = (v_cnt_d >= C_V_VIS);
   end

   // Register all state; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q         <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         addr_cnt_q    <= '0;
         ram_addr_q    <= '0;
         ram_rd_q      <= 1'b0;
         hs1_q         <= 1'b0;
         vs1_q         <= 1'b0;
         act1_q        <= 1'b0;
         rgb_q         <= 3'b000;
         vga_hs_q      <= ~HS_POL;
         vga_vs_q      <= ~VS_POL;
         frame_start_q <= 1'b0;
         vblank_q      <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         addr_cnt_q    <= addr_cnt_d;
         ram_addr_q    <= ram_addr_d;
         ram_rd_q      <= ram_rd_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         act1_q        <= act1_d;
         rgb_q         <= rgb_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         frame_start_q <= frame_start_d;
         vblank_q      <= vblank_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ram_addr    = ram_addr_q;
   assign ram_rd      = ram_rd_q;
   assign vga_r       = rgb_q[2];
   assign vga_g       = rgb_q[1];
   assign vga_b       = rgb_q[0];
   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign frame_start = frame_start_q;
   assign vblank      = vblank_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_ram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_vga_ram_reader                                          |
// | Purpose  : Self-checking bench for vga_ram_reader on a reduced raster  |
// |            geometry, with a latency-1 RAM returning addr[2:0].         |
// | Revision : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_vga_ram_reader;

   localparam int HV = 16;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VV = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int PD = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [18:0] ram_addr;
   logic        ram_rd;
   logic [2:0]  ram_q;
   logic        vga_r;
   logic        vga_g;
   logic        vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        frame_start;
   logic        vblank;

   vga_ram_reader #(
      .H_VISIBLE   (HV),
      .H_FRONT     (HF),
      .H_SYNC      (HS),
      .H_BACK      (HB),
      .V_VISIBLE   (VV),
      .V_FRONT     (VF),
      .V_SYNC      (VS),
      .V_BACK      (VB),
      .PIX_DIV     (PD),
      .RAM_LATENCY (1),
      .HS_POL      (1'b0),
      .VS_POL      (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .ram_addr    (ram_addr),
      .ram_rd      (ram_rd),
      .ram_q       (ram_q),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .frame_start (frame_start),
      .vblank      (vblank)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: one-clk latency, returns all ones when not being read
   always @(posedge clk) begin
      ram_q <= ram_rd ? ram_addr[2:0] : 3'b111;
   end

   int n_tests;
   int n_fail;

   // Model state
   int         phase;
   int         pos;
   logic [4:0] vq[$];
   logic [2:0] e_rgb;
   logic       e_hs;
   logic       e_vs;
   logic       e_rd;
   logic       e_fs;
   logic       e_vb;
   logic       e_addr_chk;
   int         e_addr;
   int         hs_low;
   int         vs_low;
   int         fs_gap;
   bit         gap_valid;
   int         last_act;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {rgb,hs,vs} for raster position p, sync active low
   function automatic logic [4:0] pix_exp(input int p);
      int         h;
      int         v;
      logic       a;
      logic [2:0] c;
      h = p % HT;
      v = p / HT;
      a = (h < HV) && (v < VV);
      c = a ? 3'((v * HV + h) % 8) : 3'b000;
      return {c,
              !((h >= HV + HF) && (h < HV + HF + HS)),
              !((v >= VV + VF) && (v < VV + VF + VS))};
   endfunction

   task automatic go_idle();
      phase = 0;
      pos   = 0;
      vq.delete();
      vq.push_back(5'b000_1_1);
      e_rgb      = 3'b000;
      e_hs       = 1'b1;
      e_vs       = 1'b1;
      e_rd       = 1'b0;
      e_addr     = 0;
      e_addr_chk = 1'b1;
      e_vb       = 1'b0;
      gap_valid  = 1'b0;
      hs_low     = 0;
      vs_low     = 0;
   endtask

   // One clock: advance the model across the posedge, compare at negedge
   task automatic step();
      logic [4:0] it;
      int         h;
      int         v;
      @(posedge clk);
      e_fs = 1'b0;
      if (!rst_n || !enable) begin
         go_idle();
      end else if (phase == PD - 1) begin
         phase = 0;
         h = pos % HT;
         v = pos / HT;
         e_rd       = (h < HV) && (v < VV);
         e_addr_chk = e_rd;
         e_addr     = v * HV + h;
         e_fs       = (pos == 0);
         vq.push_back(pix_exp(pos));
         it = vq.pop_front();
         {e_rgb, e_hs, e_vs} = it;
         pos  = (pos + 1) % FRAME;
         e_vb = ((pos / HT) >= VV);
      end else begin
         phase++;
      end
      @(negedge clk);
      check("rgb", int'({vga_r, vga_g, vga_b}), int'(e_rgb));
      check("vga_hs", int'(vga_hs), int'(e_hs));
      check("vga_vs", int'(vga_vs), int'(e_vs));
      check("ram_rd", int'(ram_rd), int'(e_rd));
      check("frame_start", int'(frame_start), int'(e_fs));
      check("vblank", int'(vblank), int'(e_vb));
      if (e_addr_chk) check("ram_addr", int'(ram_addr), e_addr);
      else            check("addr_bound", int'(ram_addr <= 19'(HV * VV - 1)), 1);

      // Pulse-width and period measurements on the outputs themselves
      if (!vga_hs) hs_low++;
      else begin
         if (hs_low != 0) check("hs_width_clk", hs_low, HS * PD);
         hs_low = 0;
      end
      if (!vga_vs) vs_low++;
      else begin
         if (vs_low != 0) check("vs_width_clk", vs_low, VS * HT * PD);
         vs_low = 0;
      end
      fs_gap++;
      if (frame_start) begin
         if (gap_valid) begin
            check("fs_period_clk", fs_gap, FRAME * PD);
            check("last_active_addr", last_act, HV * VV - 1);
         end
         gap_valid = 1'b1;
         fs_gap    = 0;
      end
      if (ram_rd) last_act = int'(ram_addr);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 2 * FRAME * PD; i++) begin
         if (pos == target) break;
         step();
      end
      check("reached_position", pos, target);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      fs_gap   = 0;
      last_act = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      go_idle();

      // Reset, then idle with enable low
      repeat (4) step();
      rst_n = 1'b1;
      repeat (3) step();

      // Two-plus uninterrupted frames
      enable = 1'b1;
      repeat (2 * FRAME * PD + 50) step();

      // Drop enable mid-line 3 for 10 clk, then restart
      run_to(3 * HT + 5);
      enable = 1'b0;
      repeat (10) step();
      enable = 1'b1;
      repeat (FRAME * PD + 40) step();

      // One-clk reset mid-line 4
      run_to(4 * HT + 8);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (FRAME * PD + 40) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_ram_reader.md
Name: vga_ram_reader

Overview:
- Scan-out side of the radar frame buffer. Reads the 640x480, 3-bit-per-pixel video RAM in raster order and generates VGA timing.
- Drives pixel colour and sync outputs with pipeline alignment that compensates for RAM read latency.
- Counterpart to the FIFO-to-RAM sector writer: the writer owns the RAM write port, this block owns the read port.
- Provides frame_start and vblank so upstream logic can align updates to the frame.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel
- RAM_LATENCY, 1, clk cycles from ram_addr to valid ram_q
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  scan-out run; low holds the block idle
- ram_addr  out  19  read address = line*H_VISIBLE + pixel
- ram_rd  out  1  read strobe; high for active pixels only
- ram_q  in  3  RAM read data {r,g,b}
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- frame_start  out  1  one-clk pulse at start of each frame
- vblank  out  1  high while line counter >= V_VISIBLE

Behaviour:
- Elaboration check: RAM_LATENCY <= PIX_DIV-1, otherwise error. Defaults are legal.
- H_TOTAL = 800 and V_TOTAL = 525 (sums of the respective parameters).
- Pixel tick:
  - Counter div runs 0..PIX_DIV-1; tick = (div == PIX_DIV-1) && enable.
  - Every other register advances only on tick.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on h wrap; it runs 0..V_TOTAL-1 and wraps to 0.
- Active region: act = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Address generation:
  - Incremental address counter, no multiplier.
  - Cleared to 0 when the counters wrap to (0,0).
  - Incremented by 1 after each active pixel.
  - Maximum value 307199; it must never exceed H_VISIBLE*V_VISIBLE-1.
- Stage 1 (registered on tick from counter state):
  - ram_addr = address counter.
  - ram_rd = act.
  - hs1 = (h_cnt in [H_VISIBLE+H_FRONT, +H_SYNC)), i.e. [656,752).
  - vs1 = (v_cnt in [490,492)).
  - act1 = act.
  - ram_addr and ram_rd are held stable for the full pixel period.
- Stage 2 (next tick):
  - {vga_r,vga_g,vga_b} = act1 ? ram_q : 3'b000.
  - vga_hs = hs1 ? HS_POL : ~HS_POL; vga_vs likewise with VS_POL.
- Latency: RGB and sync outputs lag the counters by 2 ticks and ram_addr by 1 tick. Colour and sync stay mutually aligned.
- frame_start: one-clk pulse on the tick where the counters wrap to (0,0). vblank is a level derived from v_cnt (counter domain).
- Reset values:
  - div, h_cnt, v_cnt, address counter: 0.
  - ram_addr = 0, ram_rd = 0.
  - RGB = 0.
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL.
  - frame_start = 0, vblank = 0.
- enable low:
  - Same state as reset is forced synchronously; counters are held.
  - On re-enable, scan starts at (0,0) with address 0. The first tick after enable rises produces a frame_start pulse.
- Reset mid-frame: immediate return to reset values on the next clk edge. No partial-frame continuation.
- ram_q is ignored when act1 = 0; RGB is forced to black in blanking.
- No backpressure: RAM must accept a read every PIX_DIV cycles.

Test Plan:
- Reset then enable=1 with defaults:
  - frame_start pulses once.
  - Across line 0, ram_addr steps 0..639, one value per 2 clk, with ram_rd=1.
  - ram_rd=0 for h=640..799.
- Line timing:
  - vga_hs is low (HS_POL=0) for exactly 96 ticks (192 clk) per line.
  - The falling edge occurs 656 ticks after the first active pixel on the output.
  - Line period is 1600 clk.
- Frame timing:
  - vga_vs is low for exactly 2 lines (3200 clk).
  - frame_start period is 840000 clk.
  - Last active ram_addr = 307199; the next frame restarts at 0.
  - vblank is high for 45 lines.
- Data alignment:
  - RAM model with latency 1 returning ram_q = addr[2:0].
  - Output RGB sequence on line 1 is 0,1,...,7 repeating (address 640 onward), with the first colour exactly 2 ticks after counter h=0.
  - RGB = 000 throughout blanking even with ram_q = 3'b111.
- enable dropped at line 100, pixel 300, for 10 clk:
  - Outputs go idle (black, syncs inactive, ram_rd=0).
  - After re-enable, ram_addr restarts at 0 and frame_start pulses.
- rst_n asserted for 1 clk mid-line 200:
  - All outputs show reset values next cycle.
  - After release with enable=1, the address sequence restarts from 0.
